// File: rtl/coll_inject_sched.sv
// coll_inject_sched: shares the collective router's single injection port among
// NREQ local requesters. Grants round-robin, captures the winner's descriptor,
// streams its payload beats, waits for router done (with timeout) and returns a
// per-requester completion pulse.
module coll_inject_sched #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4,
    parameter int TMO   = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*(31+LEN_W)-1:0]    req_desc,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*32-1:0]            pl_data,
    input  logic [NREQ-1:0]               pl_valid,
    output logic [NREQ-1:0]               pl_ready,
    input  logic [2:0]                    src_z,
    input  logic [2:0]                    src_y,
    input  logic [2:0]                    src_x,
    input  logic [8:0]                    rank_base,
    output logic                          valid_in,
    output logic [2:0]                    dst_z,
    output logic [2:0]                    dst_y,
    output logic [2:0]                    dst_x,
    output logic [2:0]                    src_z_o,
    output logic [2:0]                    src_y_o,
    output logic [2:0]                    src_x_o,
    output logic [8:0]                    rank,
    output logic [7:0]                    contextId,
    output logic [7:0]                    tag,
    output logic [1:0]                    algtype,
    output logic [3:0]                    op,
    output logic [31:0]                   payload,
    input  logic                          router_done,
    output logic [NREQ-1:0]               cpl_valid,
    output logic                          cpl_err,
    output logic                          busy
);

    localparam int DESC_W = 31 + LEN_W;
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMO_W  = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, CPL} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   beat_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               done_latch;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic [DESC_W-1:0]  sel_desc;
    logic [31:0]        cur_data;
    logic               cur_valid;

    // Round-robin pick: first pending requester at or after rr_ptr, wrapping.
    // NREQ is a power of two so the index addition wraps naturally.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign sel_desc  = req_desc[int'(sel_idx)*DESC_W +: DESC_W];
    assign cur_data  = pl_data[int'(grant)*32 +: 32];
    assign cur_valid = pl_valid[grant];
    assign busy      = (state != IDLE);

    // Payload handshake is open only to the granted requester while issuing.
    always_comb begin
        pl_ready = '0;
        if (state == ISSUE) begin
            pl_ready[grant] = 1'b1;
        end
    end

    // Scheduler FSM with all router fields and handshake pulses registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            len_reg    <= '0;
            beat_cnt   <= '0;
            tmo_cnt    <= '0;
            done_latch <= 1'b0;
            req_ready  <= '0;
            valid_in   <= 1'b0;
            payload    <= '0;
            cpl_valid  <= '0;
            cpl_err    <= 1'b0;
            op         <= '0;
            algtype    <= '0;
            tag        <= '0;
            contextId  <= '0;
            dst_z      <= '0;
            dst_y      <= '0;
            dst_x      <= '0;
            src_z_o    <= '0;
            src_y_o    <= '0;
            src_x_o    <= '0;
            rank       <= '0;
        end else begin
            req_ready <= '0;
            cpl_valid <= '0;
            case (state)
                IDLE: begin
                    valid_in <= 1'b0;
                    if (sel_found) begin
                        grant              <= sel_idx;
                        req_ready[sel_idx] <= 1'b1;
                        op                 <= sel_desc[DESC_W-1 -: 4];
                        algtype            <= sel_desc[DESC_W-5 -: 2];
                        tag                <= sel_desc[DESC_W-7 -: 8];
                        contextId          <= sel_desc[DESC_W-15 -: 8];
                        dst_z              <= sel_desc[LEN_W+8 -: 3];
                        dst_y              <= sel_desc[LEN_W+5 -: 3];
                        dst_x              <= sel_desc[LEN_W+2 -: 3];
                        len_reg            <= sel_desc[LEN_W-1:0];
                        src_z_o            <= src_z;
                        src_y_o            <= src_y;
                        src_x_o            <= src_x;
                        rank               <= rank_base + 9'(sel_idx);
                        beat_cnt           <= '0;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A done that arrives before the last beat must not be lost.
                    if (router_done) begin
                        done_latch <= 1'b1;
                    end
                    if (cur_valid) begin
                        payload  <= cur_data;
                        valid_in <= 1'b1;
                        if (beat_cnt == len_reg) begin
                            beat_cnt <= '0;
                            tmo_cnt  <= '0;
                            state    <= WAIT_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else begin
                        valid_in <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    valid_in <= 1'b0;
                    if (router_done || done_latch) begin
                        cpl_valid[grant] <= 1'b1;
                        cpl_err          <= 1'b0;
                        state            <= CPL;
                    end else if (tmo_cnt == TMO_W'(TMO-1)) begin
                        cpl_valid[grant] <= 1'b1;
                        cpl_err          <= 1'b1;
                        state            <= CPL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CPL: begin
                    cpl_err    <= 1'b0;
                    done_latch <= 1'b0;
                    tmo_cnt    <= '0;
                    rr_ptr     <= grant + 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coll_inject_sched.sv
// Directed bench for coll_inject_sched: reset state, round-robin, single op,
// payload bubbles, early done, timeout and reset mid-issue.
module tb_coll_inject_sched;

    localparam int NREQ = 4;
    localparam int DW   = 35;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_desc;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  pl_data;
    logic [NREQ-1:0]     pl_valid;
    logic [NREQ-1:0]     pl_ready;
    logic [2:0]          src_z, src_y, src_x;
    logic [8:0]          rank_base;
    logic                valid_in;
    logic [2:0]          dst_z, dst_y, dst_x, src_z_o, src_y_o, src_x_o;
    logic [8:0]          rank;
    logic [7:0]          contextId, tag;
    logic [1:0]          algtype;
    logic [3:0]          op;
    logic [31:0]         payload;
    logic                router_done;
    logic [NREQ-1:0]     cpl_valid;
    logic                cpl_err;
    logic                busy;

    int checks = 0;
    int errors = 0;

    coll_inject_sched #(.NREQ(NREQ), .LEN_W(4), .TMO(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_desc(req_desc), .req_ready(req_ready),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .src_z(src_z), .src_y(src_y), .src_x(src_x), .rank_base(rank_base),
        .valid_in(valid_in), .dst_z(dst_z), .dst_y(dst_y), .dst_x(dst_x),
        .src_z_o(src_z_o), .src_y_o(src_y_o), .src_x_o(src_x_o),
        .rank(rank), .contextId(contextId), .tag(tag), .algtype(algtype),
        .op(op), .payload(payload), .router_done(router_done),
        .cpl_valid(cpl_valid), .cpl_err(cpl_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [3:0] o, input logic [1:0] a,
                                         input logic [7:0] t, input logic [7:0] c,
                                         input logic [2:0] dz, input logic [2:0] dy,
                                         input logic [2:0] dx, input logic [3:0] l);
        return {o, a, t, c, dz, dy, dx, l};
    endfunction

    task automatic set_desc(input int i, input logic [DW-1:0] d);
        req_desc[i*DW +: DW] = d;
    endtask

    task automatic set_pl(input int i, input logic v, input logic [31:0] d);
        pl_valid[i]        = v;
        pl_data[i*32 +: 32] = d;
    endtask

    logic [6:0]  pat;
    logic [31:0] nb;

    initial begin
        rst = 1'b0; req_valid = '0; req_desc = '0; pl_data = '0; pl_valid = '0;
        src_z = 3'd5; src_y = 3'd3; src_x = 3'd1; rank_base = 9'd100; router_done = 1'b0;
        pat = 7'b1011001;
        nb  = '0;

        // Reset state
        step(); step();
        chk("rst_valid_in", valid_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_pl_ready", pl_ready, 0);
        chk("rst_cpl_valid", cpl_valid, 0);
        chk("rst_tag", tag, 0);
        chk("rst_rank", rank, 0);
        rst = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Round-robin: all four pending, len=0, done held high
        for (int i = 0; i < NREQ; i++) begin
            set_desc(i, mk(4'd2, 2'd1, 8'h10 + 8'(i), 8'h20, 3'd0, 3'd0, 3'd0, 4'd0));
            set_pl(i, 1'b1, 32'hA0 + 32'(i));
        end
        req_valid = 4'b1111;
        router_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_req_ready", req_ready, 4'b0001 << (k % 4));
            chk("rr_tag", tag, 8'h10 + 8'(k % 4));
            chk("rr_rank", rank, 9'd100 + 9'(k % 4));
            chk("rr_pl_ready", pl_ready, 4'b0001 << (k % 4));
            step();
            chk("rr_req_ready_w", req_ready, 0);
            chk("rr_valid_in", valid_in, 1);
            chk("rr_payload", payload, 32'hA0 + 32'(k % 4));
            step();
            chk("rr_cpl_valid", cpl_valid, 4'b0001 << (k % 4));
            chk("rr_cpl_err", cpl_err, 0);
            chk("rr_req_ready_c", req_ready, 0);
            if (k == 4) begin
                req_valid = '0;
                router_done = 1'b0;
                pl_valid = '0;
            end
            step();
            chk("rr_idle_req_ready", req_ready, 0);
            chk("rr_idle_cpl", cpl_valid, 0);
        end

        // Single op: req 0, op=8, tag=1, len=5, payload 6..1
        set_desc(0, mk(4'b1000, 2'd2, 8'd1, 8'h22, 3'd1, 3'd2, 3'd3, 4'd5));
        req_valid = 4'b0001;
        step();
        chk("s_req_ready", req_ready, 4'b0001);
        chk("s_busy", busy, 1);
        chk("s_pl_ready", pl_ready, 4'b0001);
        chk("s_op", op, 4'b1000);
        chk("s_alg", algtype, 2'd2);
        chk("s_ctx", contextId, 8'h22);
        chk("s_dst", {dst_z, dst_y, dst_x}, {3'd1, 3'd2, 3'd3});
        chk("s_src", {src_z_o, src_y_o, src_x_o}, {3'd5, 3'd3, 3'd1});
        chk("s_rank", rank, 9'd100);
        req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            set_pl(0, 1'b1, 32'(6 - i));
            step();
            chk("s_valid_in", valid_in, 1);
            chk("s_payload", payload, 32'(6 - i));
            chk("s_tag", tag, 8'd1);
            chk("s_op_hold", op, 4'b1000);
        end
        pl_valid = '0;
        step();
        chk("s_valid_in_low", valid_in, 0);
        step(); step();
        chk("s_no_cpl_yet", cpl_valid, 0);
        router_done = 1'b1;
        step();
        chk("s_cpl_valid", cpl_valid, 4'b0001);
        chk("s_cpl_err", cpl_err, 0);
        router_done = 1'b0;
        step();
        chk("s_cpl_clear", cpl_valid, 0);
        chk("s_idle_busy", busy, 0);
        chk("s_idle_tag_hold", tag, 8'd1);

        // Bubbles: req 2, len=3, pl_valid pattern 1,0,0,1,1,0,1; req 1 drives noise
        set_desc(2, mk(4'd3, 2'd0, 8'h33, 8'h44, 3'd4, 3'd4, 3'd4, 4'd3));
        set_pl(1, 1'b1, 32'hDEAD);
        req_valid = 4'b0100;
        step();
        chk("b_req_ready", req_ready, 4'b0100);
        chk("b_pl_ready", pl_ready, 4'b0100);
        chk("b_rank", rank, 9'd102);
        req_valid = '0;
        for (int j = 0; j < 7; j++) begin
            set_pl(2, pat[j], 32'h100 + nb);
            step();
            chk("b_valid_in", valid_in, pat[j]);
            if (pat[j]) begin
                chk("b_payload", payload, 32'h100 + nb);
                nb = nb + 1;
            end
            chk("b_tag", tag, 8'h33);
            chk("b_op", op, 4'd3);
        end
        chk("b_beats", nb, 4);
        pl_valid = '0;
        router_done = 1'b1;
        step();
        chk("b_cpl_valid", cpl_valid, 4'b0100);
        router_done = 1'b0;
        step();

        // Early done: req 3, len=3, router_done during the 2nd beat
        set_desc(3, mk(4'd5, 2'd3, 8'h77, 8'h01, 3'd0, 3'd1, 3'd2, 4'd3));
        req_valid = 4'b1000;
        step();
        chk("e_req_ready", req_ready, 4'b1000);
        req_valid = '0;
        for (int b = 0; b < 4; b++) begin
            set_pl(3, 1'b1, 32'h300 + 32'(b));
            router_done = (b == 1);
            step();
            chk("e_payload", payload, 32'h300 + 32'(b));
        end
        router_done = 1'b0;
        pl_valid = '0;
        chk("e_wait_no_cpl", cpl_valid, 0);
        step();
        chk("e_cpl_valid", cpl_valid, 4'b1000);
        chk("e_cpl_err", cpl_err, 0);
        step();

        // Timeout: req 1, len=0, no router_done
        set_desc(1, mk(4'd1, 2'd0, 8'h55, 8'h02, 3'd0, 3'd0, 3'd0, 4'd0));
        req_valid = 4'b0010;
        step();
        chk("t_req_ready", req_ready, 4'b0010);
        req_valid = '0;
        set_pl(1, 1'b1, 32'hBEEF);
        step();
        chk("t_valid_in", valid_in, 1);
        pl_valid = '0;
        for (int k = 1; k < 16; k++) begin
            step();
            chk("t_no_cpl", cpl_valid, 0);
        end
        step();
        chk("t_cpl_valid", cpl_valid, 4'b0010);
        chk("t_cpl_err", cpl_err, 1);
        step();
        chk("t_err_clear", cpl_err, 0);
        set_desc(0, mk(4'd6, 2'd1, 8'h44, 8'h03, 3'd0, 3'd0, 3'd0, 4'd0));
        req_valid = 4'b0001;
        step();
        chk("t_next_grant", req_ready, 4'b0001);
        req_valid = '0;
        set_pl(0, 1'b1, 32'h1234);
        router_done = 1'b1;
        step();
        pl_valid = '0;
        step();
        chk("t_next_cpl", cpl_valid, 4'b0001);
        chk("t_next_err", cpl_err, 0);
        router_done = 1'b0;
        step();

        // Reset mid-ISSUE: req 0 len=5, reset at beat 2
        set_desc(0, mk(4'd7, 2'd2, 8'h99, 8'h04, 3'd0, 3'd0, 3'd0, 4'd5));
        set_desc(1, mk(4'd2, 2'd1, 8'h66, 8'h05, 3'd0, 3'd0, 3'd0, 4'd0));
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        set_pl(0, 1'b1, 32'h11);
        step();
        set_pl(0, 1'b1, 32'h22);
        step();
        chk("r_beat2", payload, 32'h22);
        rst = 1'b0;
        #1;
        chk("r_valid_in", valid_in, 0);
        chk("r_busy", busy, 0);
        chk("r_req_ready", req_ready, 0);
        chk("r_pl_ready", pl_ready, 0);
        chk("r_cpl_valid", cpl_valid, 0);
        chk("r_tag", tag, 0);
        pl_valid = '0;
        req_valid = 4'b1010;
        step();
        chk("r_hold_cpl", cpl_valid, 0);
        rst = 1'b1;
        step();
        chk("r_first_grant", req_ready, 4'b0010);
        chk("r_first_tag", tag, 8'h66);
        req_valid = '0;
        set_pl(1, 1'b1, 32'h66);
        router_done = 1'b1;
        step();
        pl_valid = '0;
        step();
        chk("r_cpl", cpl_valid, 4'b0010);
        router_done = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
